// File: rtl/cac_pkg.sv
// cac_pkg: shared types and helpers for the cache data slice.
//  - fill_state_t : line-fill sequencer states
//  - odd_par()    : odd-parity bit for a word (zero-extend narrower words;
//                   the extra zeros do not change the result)
//  - CAC_LINE_W   : default log2 of words per cache line
package cac_pkg;

  localparam int CAC_LINE_W = 2;
  localparam int CAC_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Parity bit that makes the total count of ones (data + parity) odd.
  function automatic logic odd_par(input logic [CAC_MAX_W-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/cac_way_ram.sv
// cac_way_ram: storage for one cache way, DW bits x 2**AW entries.
//  Ports:
//   clk    in  clock
//   reset  in  asynchronous active-high reset (read register only; array is not reset)
//   we     in  write enable
//   wadr   in  write index
//   wdata  in  write word ({parity, data})
//   radr   in  read index, sampled every cycle
//   rdata  out registered read word; a same-cycle write to radr is forwarded
module cac_way_ram #(
  parameter int DW = 10,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] radr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];
  logic [DW-1:0] rdata_r;

  // Array write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wadr] <= wdata;
    end
  end

  // Registered read; forward the word being written so a read-during-write sees new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r <= {DW{1'b0}};
    end else if (we && (wadr == radr)) begin
      rdata_r <= wdata;
    end else begin
      rdata_r <= mem_r[radr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/cac_data_slice.sv
// cac_data_slice: parametrised cache data slice (WAYS ways of W data bits + odd parity).
//  Registered read of the selected way, single-word CPU writes, and a 4-word
//  (2**LINE_W) line-fill sequencer that wraps within the line.
//  Optional feature macro: CAC_PAR_CHECK_EN (read-side parity checking with a sticky error).
//  Ports:
//   clk, reset                  clock / asynchronous active-high reset
//   cache_adr, csh_sel_l        read/write index and active-low way select (lowest way wins)
//   cache_wr_l                  active-low CPU write strobe
//   mem_to_cache, par_flip      write/fill data and parity-inversion for error injection
//   fill_start/way/adr/valid    line-fill control; fill_busy/fill_done report progress
//   cache_data, csh_par_bit     registered read word and its stored parity
//   par_err, par_err_way        sticky parity error and way of the first error; par_err_clr clears
module cac_data_slice
  import cac_pkg::*;
#(
  parameter int W      = 9,
  parameter int WAYS   = 4,
  parameter int IDX_W  = 9,
  parameter int LINE_W = CAC_LINE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IDX_W-1:0]        cache_adr,
  input  logic [WAYS-1:0]         csh_sel_l,
  input  logic                    cache_wr_l,
  input  logic [W-1:0]            mem_to_cache,
  input  logic                    par_flip,
  input  logic                    fill_start,
  input  logic [$clog2(WAYS)-1:0] fill_way,
  input  logic [IDX_W-1:0]        fill_adr,
  input  logic                    fill_valid,
  output logic                    fill_busy,
  output logic                    fill_done,
  output logic [W-1:0]            cache_data,
  output logic                    csh_par_bit,
  output logic                    par_err,
  output logic [$clog2(WAYS)-1:0] par_err_way,
  input  logic                    par_err_clr
);

  localparam int WAY_W = $clog2(WAYS);

  // ---------------------------------------------------------------- way select
  logic [WAY_W-1:0] cpu_way_s;
  logic             cpu_sel_s;

  // Priority-encode the active-low select; scanning downward leaves the lowest way.
  always_comb begin
    cpu_way_s = {WAY_W{1'b0}};
    cpu_sel_s = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      cpu_way_s = (!csh_sel_l[i]) ? WAY_W'(i) : cpu_way_s;
      cpu_sel_s = cpu_sel_s | ~csh_sel_l[i];
    end
  end

  // ---------------------------------------------------------------- fill sequencer
  fill_state_t      state_r, state_nxt_s;
  logic [LINE_W-1:0] cnt_r, cnt_nxt_s;
  logic [WAY_W-1:0]  fill_way_r;
  logic [IDX_W-1:0]  fill_adr_r;
  logic              fill_latch_s;
  logic              fill_we_s;
  logic              fill_busy_r;
  logic              fill_done_r;
  logic [IDX_W-1:0]  fill_idx_s;

  // Next-state logic; a fill write happens on every valid word while in FILL.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    fill_latch_s = 1'b0;
    fill_we_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fill_start) begin
          state_nxt_s  = FILL;
          cnt_nxt_s    = {LINE_W{1'b0}};
          fill_latch_s = 1'b1;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      FILL: begin
        if (fill_valid) begin
          fill_we_s = 1'b1;
          cnt_nxt_s = cnt_r + LINE_W'(1);
          if (cnt_r == {LINE_W{1'b1}}) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = FILL;
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Sequencer state, word counter and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {LINE_W{1'b0}};
      fill_busy_r <= 1'b0;
      fill_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      fill_busy_r <= (state_nxt_s == FILL);
      fill_done_r <= (state_nxt_s == DONE);
    end
  end

  // Capture the fill target when a fill is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_way_r <= {WAY_W{1'b0}};
      fill_adr_r <= {IDX_W{1'b0}};
    end else if (fill_latch_s) begin
      fill_way_r <= fill_way;
      fill_adr_r <= fill_adr;
    end else begin
      fill_way_r <= fill_way_r;
      fill_adr_r <= fill_adr_r;
    end
  end

  // Word offset wraps inside the line (the LINE_W-bit sum drops its carry).
  assign fill_idx_s = {fill_adr_r[IDX_W-1:LINE_W], fill_adr_r[LINE_W-1:0] + cnt_r};

  assign fill_busy = fill_busy_r;
  assign fill_done = fill_done_r;

  // ---------------------------------------------------------------- write port
  // Each way has one write port, so a fill word pre-empts any CPU write that cycle.
  logic             cpu_we_s;
  logic [IDX_W-1:0] wadr_s;
  logic [W:0]       wdata_s;
  logic [W:0]       rd_words_s [WAYS];

  assign cpu_we_s = !cache_wr_l && cpu_sel_s && !fill_we_s;
  assign wadr_s   = fill_we_s ? fill_idx_s : cache_adr;
  assign wdata_s  = {odd_par(CAC_MAX_W'(mem_to_cache)) ^ par_flip, mem_to_cache};

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    localparam logic [WAY_W-1:0] WAY_ID = WAY_W'(g);
    logic we_s;

    assign we_s = (fill_we_s && (fill_way_r == WAY_ID)) ||
                  (cpu_we_s  && (cpu_way_s  == WAY_ID));

    cac_way_ram #(
      .DW (W + 1),
      .AW (IDX_W)
    ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (we_s),
      .wadr  (wadr_s),
      .wdata (wdata_s),
      .radr  (cache_adr),
      .rdata (rd_words_s[g])
    );
  end

  // ---------------------------------------------------------------- read mux
  logic [WAY_W-1:0] sel_way_r;
  logic             sel_any_r;
  logic [W:0]       rd_word_s;

  // Way choice is registered alongside the RAM read data so both line up in cycle N+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_way_r <= {WAY_W{1'b0}};
      sel_any_r <= 1'b0;
    end else begin
      sel_way_r <= cpu_way_s;
      sel_any_r <= cpu_sel_s;
    end
  end

  // Select among already-registered way outputs; no way selected reads as zero.
  always_comb begin
    rd_word_s = {(W + 1){1'b0}};
    if (sel_any_r) begin
      rd_word_s = rd_words_s[sel_way_r];
    end else begin
      rd_word_s = {(W + 1){1'b0}};
    end
  end

  assign cache_data  = rd_word_s[W-1:0];
  assign csh_par_bit = rd_word_s[W];

  // ---------------------------------------------------------------- parity check
`ifdef CAC_PAR_CHECK_EN
  logic             par_mis_s;
  logic             par_err_r;
  logic [WAY_W-1:0] par_err_way_r;

  assign par_mis_s = sel_any_r && (odd_par(CAC_MAX_W'(rd_word_s[W-1:0])) != rd_word_s[W]);

  // Sticky error: a new mismatch beats a clear; only the first failing way is logged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_r     <= 1'b0;
      par_err_way_r <= {WAY_W{1'b0}};
    end else if (par_mis_s) begin
      par_err_r <= 1'b1;
      if (!par_err_r) begin
        par_err_way_r <= sel_way_r;
      end else begin
        par_err_way_r <= par_err_way_r;
      end
    end else if (par_err_clr) begin
      par_err_r     <= 1'b0;
      par_err_way_r <= {WAY_W{1'b0}};
    end else begin
      par_err_r     <= par_err_r;
      par_err_way_r <= par_err_way_r;
    end
  end

  assign par_err     = par_err_r;
  assign par_err_way = par_err_way_r;
`else
  logic unused_par_clr_s;

  assign unused_par_clr_s = par_err_clr;
  assign par_err          = 1'b0;
  assign par_err_way      = {WAY_W{1'b0}};
`endif

endmodule

// File: tb/tb_cac_data_slice.sv
// tb_cac_data_slice: directed-vector bench for cac_data_slice.
//  Covers reset values, CPU write/read with bypass, wrapped line fills (with gaps,
//  ignored restarts and CPU-write collisions), lowest-way-wins selection, parity
//  error injection (expectations depend on CAC_PAR_CHECK_EN) and reset mid-fill.
module tb_cac_data_slice;

  logic       clk;
  logic       reset;
  logic [8:0] cache_adr;
  logic [3:0] csh_sel_l;
  logic       cache_wr_l;
  logic [8:0] mem_to_cache;
  logic       par_flip;
  logic       fill_start;
  logic [1:0] fill_way;
  logic [8:0] fill_adr;
  logic       fill_valid;
  logic       fill_busy;
  logic       fill_done;
  logic [8:0] cache_data;
  logic       csh_par_bit;
  logic       par_err;
  logic [1:0] par_err_way;
  logic       par_err_clr;

  int vec_cnt_r;
  int miscmp_cnt_r;

`ifdef CAC_PAR_CHECK_EN
  localparam logic       EXP_ERR     = 1'b1;
  localparam logic [1:0] EXP_ERR_WAY = 2'd3;
`else
  localparam logic       EXP_ERR     = 1'b0;
  localparam logic [1:0] EXP_ERR_WAY = 2'd0;
`endif

  cac_data_slice dut (
    .clk          (clk),
    .reset        (reset),
    .cache_adr    (cache_adr),
    .csh_sel_l    (csh_sel_l),
    .cache_wr_l   (cache_wr_l),
    .mem_to_cache (mem_to_cache),
    .par_flip     (par_flip),
    .fill_start   (fill_start),
    .fill_way     (fill_way),
    .fill_adr     (fill_adr),
    .fill_valid   (fill_valid),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .cache_data   (cache_data),
    .csh_par_bit  (csh_par_bit),
    .par_err      (par_err),
    .par_err_way  (par_err_way),
    .par_err_clr  (par_err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt_r++;
    if (obs !== exp) begin
      miscmp_cnt_r++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] sel, input logic [8:0] adr,
                          input logic [8:0] exp_data, input logic exp_par);
    csh_sel_l = sel;
    cache_adr = adr;
    tick();
    check_val({tag, "_data"}, 32'(cache_data), 32'(exp_data));
    check_val({tag, "_par"}, 32'(csh_par_bit), 32'(exp_par));
    csh_sel_l = 4'b1111;
  endtask

  // Fill words in arrival order with their hand-computed odd parity.
  logic [8:0] t2_words [4] = '{9'h011, 9'h022, 9'h144, 9'h1FF};
  logic [8:0] t3_words [4] = '{9'h0C3, 9'h155, 9'h0AA, 9'h100};
  logic [8:0] t5_words [4] = '{9'h041, 9'h082, 9'h104, 9'h1F8};

  initial begin
    vec_cnt_r    = 0;
    miscmp_cnt_r = 0;
    reset        = 1'b1;
    cache_adr    = 9'h000;
    csh_sel_l    = 4'b1111;
    cache_wr_l   = 1'b1;
    mem_to_cache = 9'h000;
    par_flip     = 1'b0;
    fill_start   = 1'b0;
    fill_way     = 2'd0;
    fill_adr     = 9'h000;
    fill_valid   = 1'b0;
    par_err_clr  = 1'b0;

    // Reset values
    tick();
    tick();
    check_val("rst_data", 32'(cache_data), 32'h0);
    check_val("rst_par", 32'(csh_par_bit), 32'h0);
    check_val("rst_busy", 32'(fill_busy), 32'h0);
    check_val("rst_done", 32'(fill_done), 32'h0);
    check_val("rst_err", 32'(par_err), 32'h0);
    check_val("rst_err_way", 32'(par_err_way), 32'h0);
    reset = 1'b0;
    tick();

    // 1) CPU write way1 0x012 = 0x1A5 (5 ones -> parity 0), bypass then stored read
    csh_sel_l    = 4'b1101;
    cache_adr    = 9'h012;
    mem_to_cache = 9'h1A5;
    cache_wr_l   = 1'b0;
    tick();
    check_val("t1_bypass_data", 32'(cache_data), 32'h1A5);
    check_val("t1_bypass_par", 32'(csh_par_bit), 32'h0);
    cache_wr_l   = 1'b1;
    mem_to_cache = 9'h000;
    read_chk("t1_read", 4'b1101, 9'h012, 9'h1A5, 1'b0);
    // way3 0x013 = 0x0FF (8 ones -> parity 1)
    csh_sel_l    = 4'b0111;
    cache_adr    = 9'h013;
    mem_to_cache = 9'h0FF;
    cache_wr_l   = 1'b0;
    tick();
    cache_wr_l   = 1'b1;
    read_chk("t1_way3", 4'b0111, 9'h013, 9'h0FF, 1'b1);

    // 2) Fill way2 starting at 0x106: writes 0x106,0x107,0x104,0x105
    fill_start = 1'b1;
    fill_way   = 2'd2;
    fill_adr   = 9'h106;
    tick();
    fill_start = 1'b0;
    check_val("t2_busy", 32'(fill_busy), 32'h1);
    for (int k = 0; k < 4; k++) begin
      fill_valid   = 1'b1;
      mem_to_cache = t2_words[k];
      tick();
      if (k < 3) begin
        check_val("t2_done_early", 32'(fill_done), 32'h0);
      end else begin
        check_val("t2_done", 32'(fill_done), 32'h1);
        check_val("t2_busy_done", 32'(fill_busy), 32'h0);
      end
    end
    fill_valid = 1'b0;
    tick();
    check_val("t2_done_once", 32'(fill_done), 32'h0);
    read_chk("t2_106", 4'b1011, 9'h106, 9'h011, 1'b1);
    read_chk("t2_107", 4'b1011, 9'h107, 9'h022, 1'b1);
    read_chk("t2_104", 4'b1011, 9'h104, 9'h144, 1'b0);
    read_chk("t2_105", 4'b1011, 9'h105, 9'h1FF, 1'b0);

    // 3) Gapped fill of way0 from 0x0A1, ignored restart, CPU write collision
    fill_start = 1'b1;
    fill_way   = 2'd0;
    fill_adr   = 9'h0A1;
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 2; g++) begin
        fill_start = (k == 1 && g == 0);
        fill_way   = 2'd3;
        fill_adr   = 9'h1F0;
        tick();
        check_val("t3_gap_busy", 32'(fill_busy), 32'h1);
        check_val("t3_gap_done", 32'(fill_done), 32'h0);
      end
      fill_start   = 1'b0;
      fill_valid   = 1'b1;
      mem_to_cache = t3_words[k];
      if (k == 2) begin
        csh_sel_l  = 4'b1101;
        cache_adr  = 9'h012;
        cache_wr_l = 1'b0;
      end
      tick();
      fill_valid = 1'b0;
      cache_wr_l = 1'b1;
      csh_sel_l  = 4'b1111;
      check_val("t3_done", 32'(fill_done), (k == 3) ? 32'h1 : 32'h0);
    end
    tick();
    check_val("t3_no_restart", 32'(fill_busy), 32'h0);
    check_val("t3_done_once", 32'(fill_done), 32'h0);
    read_chk("t3_cpu_dropped", 4'b1101, 9'h012, 9'h1A5, 1'b0);
    read_chk("t3_0a1", 4'b1110, 9'h0A1, 9'h0C3, 1'b1);
    read_chk("t3_0a2", 4'b1110, 9'h0A2, 9'h155, 1'b0);
    read_chk("t3_0a3", 4'b1110, 9'h0A3, 9'h0AA, 1'b1);
    read_chk("t3_0a0", 4'b1110, 9'h0A0, 9'h100, 1'b0);
    check_val("t3_no_err", 32'(par_err), 32'h0);

    // 6) All selected -> way0 wins; none selected -> zero
    read_chk("t6_all_sel", 4'b0000, 9'h0A1, 9'h0C3, 1'b1);
    read_chk("t6_no_sel", 4'b1111, 9'h0A1, 9'h000, 1'b0);

    // 4) Parity error injection on way3 0x055 = 0x003 (good parity 1, stored 0)
    csh_sel_l    = 4'b0111;
    cache_adr    = 9'h055;
    mem_to_cache = 9'h003;
    par_flip     = 1'b1;
    cache_wr_l   = 1'b0;
    tick();
    check_val("t4_flip_data", 32'(cache_data), 32'h003);
    check_val("t4_flip_par", 32'(csh_par_bit), 32'h0);
    check_val("t4_err_before", 32'(par_err), 32'h0);
    cache_wr_l = 1'b1;
    par_flip   = 1'b0;
    tick();
    check_val("t4_err", 32'(par_err), 32'(EXP_ERR));
    check_val("t4_err_way", 32'(par_err_way), 32'(EXP_ERR_WAY));
    csh_sel_l   = 4'b1111;
    par_err_clr = 1'b1;
    tick();
    check_val("t4_set_wins", 32'(par_err), 32'(EXP_ERR));
    tick();
    par_err_clr = 1'b0;
    check_val("t4_cleared", 32'(par_err), 32'h0);
    check_val("t4_cleared_way", 32'(par_err_way), 32'h0);

    // 5) Reset after two fill words aborts the fill
    fill_start = 1'b1;
    fill_way   = 2'd1;
    fill_adr   = 9'h140;
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fill_valid   = 1'b1;
      mem_to_cache = 9'h001 + 9'(k);
      tick();
    end
    fill_valid = 1'b0;
    reset      = 1'b1;
    #1;
    check_val("t5_rst_busy", 32'(fill_busy), 32'h0);
    check_val("t5_rst_done", 32'(fill_done), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_val("t5_no_done", 32'(fill_done), 32'h0);
    check_val("t5_idle", 32'(fill_busy), 32'h0);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    check_val("t5_restart_busy", 32'(fill_busy), 32'h1);
    for (int k = 0; k < 4; k++) begin
      fill_valid   = 1'b1;
      mem_to_cache = t5_words[k];
      tick();
    end
    fill_valid = 1'b0;
    check_val("t5_done", 32'(fill_done), 32'h1);
    read_chk("t5_140", 4'b1101, 9'h140, 9'h041, 1'b1);
    read_chk("t5_143", 4'b1101, 9'h143, 9'h1F8, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt_r, miscmp_cnt_r);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
